// File: rtl/rgb_fpga_pkg.sv
// Shared types and width helpers for the RGB panel scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rgb_fpga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BLANK = 2'd2,
        LATCH = 2'd3
    } state_e;

    // On-timer must hold the longest slot, BASE_ON << (BITPLANES-1), without truncation.
    function automatic int on_timer_w(input int base_on, input int planes);
        return $clog2(base_on << (planes - 1)) + 1;
    endfunction

    function automatic int plane_w(input int planes);
        return (planes > 1) ? $clog2(planes) : 1;
    endfunction

endpackage

// File: rtl/rgb_fpga_down_counter.sv
// Loadable saturating down-counter with a registered zero flag.
// Latency: zero_o reflects the count one cycle after clear/load/decrement.
// Backpressure: none; decrement is ignored once the count reaches zero.
// Ports: clk, rst_n; clr_i (highest priority), load_i/load_val_i, dec_i; zero_o.
module rgb_fpga_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                      cnt_d = '0;
        else if (load_i)                cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
    end

    // The zero flag is computed from the next count so it is a true register
    // that lines up with cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/rgb_fpga_scan_ctrl.sv
// HUB75 row-scan / bit-plane (BCM) controller: requests line shifts, latches rows, drives oe_n.
// Latency: line_start one cycle after enable or after each latch; all outputs registered.
// Backpressure: each slot waits in WAIT until the shifter answers line_rdy and the on-time expires.
// Ports: enable/line_rdy/swap_req in; line_start + fetch_row/fetch_plane/buf_sel to the shifter;
//        matrix_addr/latch/oe_n to the panel; frame_rdy/swap_ack frame-boundary pulses.
module rgb_fpga_scan_ctrl
    import rgb_fpga_pkg::*;
#(
    parameter  int ROWS         = 16,
    parameter  int BITPLANES    = 8,
    parameter  int BASE_ON      = 4,
    parameter  int BLANK_CYCLES = 2,
    localparam int ADDR_W       = $clog2(ROWS),
    localparam int PLANE_W      = plane_w(BITPLANES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               line_rdy,
    input  logic               swap_req,
    output logic               line_start,
    output logic [ADDR_W-1:0]  fetch_row,
    output logic [PLANE_W-1:0] fetch_plane,
    output logic               buf_sel,
    output logic [ADDR_W-1:0]  matrix_addr,
    output logic               latch,
    output logic               oe_n,
    output logic               frame_rdy,
    output logic               swap_ack
);

    localparam int ON_W = on_timer_w(BASE_ON, BITPLANES);
    localparam int BL_W = $clog2(BLANK_CYCLES + 1);

    state_e             state_q;
    logic [ADDR_W-1:0]  row_q, addr_q;
    logic [PLANE_W-1:0] plane_q;
    logic               buf_q, rdy_q;
    logic               line_start_q, latch_q, frame_rdy_q, swap_ack_q;
    logic               on_zero, bl_zero;

    // A line_rdy in the same cycle as the line_start pulse cannot belong to the
    // new request, so it is not accepted.
    logic rdy_eff, go_blank, last_row, last_plane;
    assign rdy_eff    = rdy_q | (line_rdy & ~line_start_q);
    assign go_blank   = (state_q == WAIT) && on_zero && rdy_eff;
    assign last_row   = (row_q == ADDR_W'(ROWS - 1));
    assign last_plane = (plane_q == PLANE_W'(BITPLANES - 1));

    // On-timer: loaded with the weight of the plane being latched; the timer is
    // already zero in BLANK/LATCH/IDLE, so its registered zero flag is oe_n.
    rgb_fpga_down_counter #(.W(ON_W)) u_on_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (!enable || state_q == IDLE),
        .load_i     (enable && state_q == LATCH),
        .load_val_i (ON_W'(BASE_ON) << plane_q),
        .dec_i      (state_q == WAIT),
        .zero_o     (on_zero)
    );

    // Blank counter: loaded with BLANK_CYCLES-1 so BLANK lasts BLANK_CYCLES cycles.
    rgb_fpga_down_counter #(.W(BL_W)) u_blank_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (!enable),
        .load_i     (go_blank),
        .load_val_i (BL_W'(BLANK_CYCLES - 1)),
        .dec_i      (state_q == BLANK),
        .zero_o     (bl_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            buf_q        <= 1'b0;
            addr_q       <= '0;
            rdy_q        <= 1'b0;
            line_start_q <= 1'b0;
            latch_q      <= 1'b0;
            frame_rdy_q  <= 1'b0;
            swap_ack_q   <= 1'b0;
        end else if (!enable) begin
            // addr_q and buf_q deliberately keep their values across a stop.
            state_q      <= IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            rdy_q        <= 1'b0;
            line_start_q <= 1'b0;
            latch_q      <= 1'b0;
            frame_rdy_q  <= 1'b0;
            swap_ack_q   <= 1'b0;
        end else begin
            line_start_q <= 1'b0;
            latch_q      <= 1'b0;
            frame_rdy_q  <= 1'b0;
            swap_ack_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    line_start_q <= 1'b1;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (go_blank) begin
                        rdy_q   <= 1'b0;
                        state_q <= BLANK;
                    end else if (line_rdy && !line_start_q) begin
                        rdy_q <= 1'b1;
                    end
                end
                BLANK: begin
                    if (bl_zero) begin
                        state_q <= LATCH;
                        latch_q <= 1'b1;
                        addr_q  <= row_q;
                        // Frame-boundary pulses are set up here so they coincide with latch.
                        if (last_row && last_plane) begin
                            frame_rdy_q <= 1'b1;
                            if (swap_req) begin
                                buf_q      <= ~buf_q;
                                swap_ack_q <= 1'b1;
                            end
                        end
                    end
                end
                LATCH: begin
                    state_q      <= WAIT;
                    line_start_q <= 1'b1;
                    if (last_plane) begin
                        plane_q <= '0;
                        row_q   <= last_row ? '0 : row_q + ADDR_W'(1);
                    end else begin
                        plane_q <= plane_q + PLANE_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign line_start  = line_start_q;
    assign fetch_row   = row_q;
    assign fetch_plane = plane_q;
    assign buf_sel     = buf_q;
    assign matrix_addr = addr_q;
    assign latch       = latch_q;
    assign oe_n        = on_zero;
    assign frame_rdy   = frame_rdy_q;
    assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_rgb_fpga_scan_ctrl.sv
// Self-checking bench for rgb_fpga_scan_ctrl (ROWS=4, BITPLANES=3, BASE_ON=2, BLANK_CYCLES=1).
// Latency: n/a.
// Backpressure: a modelled line shifter answers each line_start after a programmable delay.
module tb_rgb_fpga_scan_ctrl;

    localparam int ROWS = 4;
    localparam int BP   = 3;
    localparam int BO   = 2;
    localparam int BC   = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       line_rdy = 1'b0;
    logic       swap_req = 1'b0;
    logic       line_start;
    logic [1:0] fetch_row;
    logic [1:0] fetch_plane;
    logic       buf_sel;
    logic [1:0] matrix_addr;
    logic       latch;
    logic       oe_n;
    logic       frame_rdy;
    logic       swap_ack;

    rgb_fpga_scan_ctrl #(
        .ROWS(ROWS), .BITPLANES(BP), .BASE_ON(BO), .BLANK_CYCLES(BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .line_rdy    (line_rdy),
        .swap_req    (swap_req),
        .line_start  (line_start),
        .fetch_row   (fetch_row),
        .fetch_plane (fetch_plane),
        .buf_sel     (buf_sel),
        .matrix_addr (matrix_addr),
        .latch       (latch),
        .oe_n        (oe_n),
        .frame_rdy   (frame_rdy),
        .swap_ack    (swap_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    // Reference model of the scan sequence
    int mrow, mplane, cur_w, run_len, last_addr;
    bit exp_buf = 1'b0;
    bit prev_oe_n = 1'b1;
    bit mon_en = 1'b0;
    int dly = 3;
    bit spur = 1'b0;
    bit dbl = 1'b0;
    int shift_cnt = -1;
    bit p_valid;
    int p_row, p_plane, p_s, p_w;
    int n_latch, n_frames, n_swaps;

    typedef struct {
        int row;
        int plane;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int dly;
        bit swap;
        bit spur;
        int n_latch;
        int exp_frames;
        int exp_swaps;
        bit exp_buf;
    } scen_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc_n);
        end
    endtask

    task automatic model_reset();
        mrow = 0; mplane = 0; cur_w = 0; run_len = 0;
        shift_cnt = -1; dbl = 1'b0; p_valid = 1'b0;
        exp_q.delete();
        prev_oe_n = 1'b1;
    endtask

    // One clock: sample outputs #1 after the edge, drive the shifter, run the scoreboard.
    task automatic cyc();
        exp_t e;
        bit   frame;
        @(posedge clk);
        #1;
        cyc_n++;

        // Shifter model: line_rdy exactly dly cycles after line_start.
        line_rdy = 1'b0;
        if (shift_cnt > 0) begin
            shift_cnt--;
            if (shift_cnt == 0) begin
                line_rdy  = 1'b1;
                shift_cnt = -1;
                dbl       = spur;
                if (p_valid) begin
                    e.row   = p_row;
                    e.plane = p_plane;
                    e.cyc   = ((p_s + p_w > cyc_n) ? p_s + p_w : cyc_n) + BC + 1;
                    exp_q.push_back(e);
                    p_valid = 1'b0;
                end
            end
        end else if (dbl) begin
            line_rdy = 1'b1;
            dbl      = 1'b0;
        end
        if (spur && latch) line_rdy = 1'b1;

        if (mon_en) begin
            if (!oe_n) begin
                run_len++;
            end else if (run_len > 0) begin
                check("oe_low_run", run_len, cur_w);
                run_len = 0;
            end

            if (latch) begin
                check("oe_n_during_latch", oe_n, 1);
                check("oe_n_before_latch", prev_oe_n, 1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL latch_unexpected: latch=1 with no ready line pending, cycle %0d", cyc_n);
                end else begin
                    e = exp_q.pop_front();
                    frame = (e.row == ROWS - 1) && (e.plane == BP - 1);
                    check("latch_cycle", cyc_n, e.cyc);
                    check("matrix_addr", matrix_addr, e.row);
                    check("frame_rdy", frame_rdy, frame);
                    check("swap_ack", swap_ack, frame && swap_req);
                    if (frame && swap_req) begin
                        exp_buf = !exp_buf;
                        n_swaps++;
                    end
                    if (frame) n_frames++;
                    check("buf_at_latch", buf_sel, exp_buf);
                    cur_w     = BO << e.plane;
                    last_addr = e.row;
                    n_latch++;
                end
            end else begin
                check("no_pulse_without_latch", frame_rdy | swap_ack, 0);
            end

            if (line_start) begin
                check("fetch_row", fetch_row, mrow);
                check("fetch_plane", fetch_plane, mplane);
                check("fetch_buf", buf_sel, exp_buf);
                p_valid   = 1'b1;
                p_row     = mrow;
                p_plane   = mplane;
                p_s       = cyc_n;
                p_w       = cur_w;
                shift_cnt = dly;
                if (mplane == BP - 1) begin
                    mplane = 0;
                    mrow   = (mrow + 1) % ROWS;
                end else begin
                    mplane++;
                end
            end
        end
        prev_oe_n = oe_n;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl[5];
        bit    found;
        tbl[0] = '{dly: 3,  swap: 1'b0, spur: 1'b0, n_latch: 12, exp_frames: 1, exp_swaps: 0, exp_buf: 1'b0};
        tbl[1] = '{dly: 3,  swap: 1'b1, spur: 1'b0, n_latch: 12, exp_frames: 1, exp_swaps: 1, exp_buf: 1'b1};
        tbl[2] = '{dly: 20, swap: 1'b0, spur: 1'b0, n_latch: 6,  exp_frames: 0, exp_swaps: 0, exp_buf: 1'b1};
        tbl[3] = '{dly: 1,  swap: 1'b1, spur: 1'b1, n_latch: 24, exp_frames: 2, exp_swaps: 2, exp_buf: 1'b1};
        tbl[4] = '{dly: 3,  swap: 1'b1, spur: 1'b1, n_latch: 11, exp_frames: 0, exp_swaps: 0, exp_buf: 1'b1};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        cyc();
        cyc();
        check("rst_line_start", line_start, 0);
        check("rst_fetch_row", fetch_row, 0);
        check("rst_fetch_plane", fetch_plane, 0);
        check("rst_buf_sel", buf_sel, 0);
        check("rst_matrix_addr", matrix_addr, 0);
        check("rst_latch", latch, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_frame_rdy", frame_rdy, 0);
        check("rst_swap_ack", swap_ack, 0);

        for (int i = 0; i < 5; i++) begin
            dly      = tbl[i].dly;
            spur     = tbl[i].spur;
            swap_req = tbl[i].swap;
            n_latch = 0; n_frames = 0; n_swaps = 0;
            enable = 1'b1;
            cyc();
            check("line_start_after_enable", line_start, 1);
            for (int k = 0; k < 3000 && n_latch < tbl[i].n_latch; k++) cyc();
            check("latch_count", n_latch, tbl[i].n_latch);
            check("frame_count", n_frames, tbl[i].exp_frames);
            check("swap_count", n_swaps, tbl[i].exp_swaps);
            check("buf_after_scenario", buf_sel, tbl[i].exp_buf);
            model_reset();
            enable = 1'b0;
            cyc();
            check("stop_oe_n", oe_n, 1);
            check("stop_latch", latch, 0);
            cyc();
            check("stop_no_line_start", line_start, 0);
            check("stop_addr_kept", matrix_addr, last_addr);
        end

        // Drop enable while the panel is lit, with a coincident line_rdy.
        dly = 3; spur = 1'b0; swap_req = 1'b0;
        n_latch = 0;
        enable = 1'b1;
        cyc();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc();
            if (n_latch >= 1 && !oe_n) found = 1'b1;
        end
        check("drop_found_oe_low", found, 1);
        mon_en = 1'b0;
        model_reset();
        enable   = 1'b0;
        line_rdy = 1'b1;
        cyc();
        check("drop_oe_n", oe_n, 1);
        check("drop_latch", latch, 0);
        check("drop_line_start", line_start, 0);
        line_rdy = 1'b0;
        cyc();
        check("drop_idle_oe_n", oe_n, 1);
        check("drop_idle_line_start", line_start, 0);
        check("drop_addr_kept", matrix_addr, last_addr);
        check("drop_buf_kept", buf_sel, exp_buf);
        mon_en = 1'b1;
        n_latch = 0;
        enable = 1'b1;
        cyc();
        check("reenable_line_start", line_start, 1);
        for (int k = 0; k < 200 && n_latch < 2; k++) cyc();
        check("reenable_latch_count", n_latch, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_fpga_scan_ctrl.md
# rgb_fpga_scan_ctrl

Parametrised row-scan and bit-plane (BCM) controller for HUB75-style RGB LED matrix panels. It sequences every row of a frame through BITPLANES binary-weighted display slots and requests line shifts from the line shifter. It drives the panel row address, latch and output-enable, and swaps double-buffered frame memory at frame boundaries. The next line is shifted while the previous one is displayed.

## Interface
Parameters:
- ROWS, 16: scanned rows per frame (≥2); ADDR_W = $clog2(ROWS)
- BITPLANES, 8: colour depth in bits (≥1); PLANE_W = max(1, $clog2(BITPLANES))
- BASE_ON, 4: oe_n-low cycles of plane 0 (≥1); plane p gets BASE_ON<<p
- BLANK_CYCLES, 2: oe_n-high dead time before each latch (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run scanning; low forces IDLE
- line_rdy  in  1  one-cycle pulse: shifter finished the line requested by the last line_start
- swap_req  in  1  level; back buffer ready, swap at next frame boundary
- line_start  out  1  one-cycle pulse: shift the line given by fetch_row/fetch_plane/buf_sel
- fetch_row  out  ADDR_W  row to fetch, stable from line_start until the next line_start
- fetch_plane  out  PLANE_W  bit plane to fetch
- buf_sel  out  1  frame buffer selected for fetching
- matrix_addr  out  ADDR_W  panel row address (row of latched data)
- latch  out  1  one-cycle panel latch strobe
- oe_n  out  1  panel output enable, active-low
- frame_rdy  out  1  one-cycle pulse: last (row, plane) of a frame latched
- swap_ack  out  1  one-cycle pulse: buf_sel toggled

## Operation
- Reset values: line_start=0, fetch_row=0, fetch_plane=0, buf_sel=0, matrix_addr=0, latch=0, oe_n=1, frame_rdy=0, swap_ack=0. The state is IDLE.
- Fetch order: planes are the inner loop (0..BITPLANES-1) and rows the outer loop (0..ROWS-1). Both wrap to 0.
- IDLE:
  - oe_n=1, fetch position is 0/0, and the on-timer is cleared.
  - enable=1 pulses line_start for (0,0) and moves to WAIT.
- WAIT:
  - The on-timer decrements each cycle, and oe_n=0 while it is non-zero.
  - A sticky rdy flag is set by line_rdy.
  - When the timer is 0 and rdy is set, the block clears rdy and moves to BLANK.
- BLANK:
  - oe_n=1 and the blank counter runs for BLANK_CYCLES cycles, then the block moves to LATCH.
- LATCH (one cycle):
  - latch=1.
  - matrix_addr takes fetch_row, and the display plane takes fetch_plane.
  - The on-timer loads BASE_ON<<plane.
  - The fetch position advances.
  - The block returns to WAIT and pulses line_start for the new position in the first WAIT cycle.
- Frame boundary: the LATCH of (ROWS-1, BITPLANES-1) is the frame boundary.
  - frame_rdy pulses.
  - If swap_req=1 in that cycle, buf_sel toggles and swap_ack pulses.
  - The following line_start uses the new buf_sel.
- enable=0 in any state returns the block to IDLE on the next edge:
  - oe_n=1, latch=0, and counters and the rdy flag are cleared.
  - matrix_addr and buf_sel are retained.
  - A line_rdy arriving in the same cycle is discarded.
- A line_rdy outside WAIT, or a second line_rdy before a new line_start, is ignored.

## Timing
- All outputs are registered.
- enable rises (sampled at edge N), so line_start=1 in cycle N+1.
- line_start is issued in the cycle after LATCH, so shifting overlaps the display interval.
- Minimum slot for plane p: max(BASE_ON<<p, shift time) + BLANK_CYCLES + 1 LATCH cycle.
- oe_n is low for exactly BASE_ON<<p consecutive cycles per slot and is never low during BLANK or LATCH.
- The on-timer width is $clog2(BASE_ON<<(BITPLANES-1))+1 bits. The shift is unsigned and must not truncate.
- The first WAIT after IDLE has the timer at 0, so no display precedes the first latch.
- latch and frame_rdy/swap_ack are asserted in the same cycle.

## Structure
- Shared package rgb_fpga_pkg holds the state enum (IDLE, WAIT, BLANK, LATCH) and the on-time width function.
- Sub-module rgb_fpga_down_counter is a loadable down-counter with a zero flag. It is used for both the on-timer and the blank counter.

## Test plan
- Reset and enable: reset with enable=0 gives all outputs at their reset values. Raising enable gives line_start one cycle later with fetch 0/0/buf 0.
- BCM weights: ROWS=4, BITPLANES=3, BASE_ON=2, BLANK_CYCLES=1, with line_rdy 3 cycles after each line_start.
  - oe_n low runs of 2, 4, 8 cycles repeating.
  - One latch per slot, each preceded by ≥1 oe_n-high cycle.
  - matrix_addr steps 0,1,2,3,0.
- Slow shifter: line_rdy 20 cycles after line_start with BASE_ON=2. oe_n low for 2 cycles, then high until line_rdy+BLANK_CYCLES, then latch.
- Frame and swap: swap_req=1 held. Coincident frame_rdy, swap_ack and latch at the (3,2) latch; the next line_start shows buf_sel=1. With swap_req=0 there is no toggle.
- Enable drop mid-WAIT with oe_n=0: oe_n=1 next cycle and the block is in IDLE. Re-enable restarts at fetch 0/0 with buf_sel kept.
- Spurious line_rdy: pulses during BLANK/LATCH or doubled pulses cause no extra latch, and the slot count is unchanged.
